// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shifter.
// Holds the op and FSM encodings and the default width constants.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHAMT_W   = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_step.sv
// One shift step: shifts work by n (0..STEP) bits according to op.
// Ports: work, n, op in; result out (combinational).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int NW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] work,
  input  logic [NW-1:0]    n,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = work;
    unique case (op)
      SH_SLL:  result = work << n;
      SH_SRL:  result = work >> n;
      SH_SRA:  result = $signed(work) >>> n;
      // a shift by WIDTH yields 0, so n==0 degenerates cleanly
      SH_ROTR: result = (work >> n) | (work << (WIDTH - int'(n)));
      default: result = work;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit, STEP bits per clock.
// Ports: clk, reset_n, start, a, shamt, op in; busy, done, y out.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [1:0]               op,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         y
);

  localparam int SW = $clog2(WIDTH);
  localparam int NW = $clog2(STEP + 1);

  if (!(STEP == 1 || STEP == 2 ||
        STEP == 4 || STEP == 8)) begin : g_bad_step
    $error("seq_shifter: STEP must be 1, 2, 4 or 8");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [SW-1:0]     rem_q, rem_d;
  shift_op_e         op_q, op_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NW-1:0]     n;
  logic [SW-1:0]     rem_nxt;
  logic [WIDTH-1:0]  step_res;

  // last step may be shorter than STEP
  always_comb begin
    n = NW'(STEP);
    if (rem_q < SW'(STEP)) n = NW'(rem_q);
    rem_nxt = rem_q - SW'(n);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .NW    (NW)
  ) u_step (
    .work   (work_q),
    .n      (n),
    .op     (op_q),
    .result (step_res)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    y_d     = y_q;
    unique case (state_q)
      S_SHIFT: begin
        work_d = step_res;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          y_d     = step_res;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (shamt == '0) begin
            y_d     = a;
            state_d = S_DONE;
          end else begin
            work_d  = a;
            rem_d   = shamt;
            op_d    = shift_op_e'(op);
            state_d = S_SHIFT;
          end
        end
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= SH_SLL;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter, STEP=1 and STEP=4 instances.
// Random and directed ops checked against an arithmetic model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        st_v    [2];
  logic [31:0] a_v     [2];
  logic [4:0]  sh_v    [2];
  logic [1:0]  op_v    [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [31:0] y_v     [2];

  int steps [2] = '{1, 4};
  int passed = 0;
  int total  = 0;
  int lat;
  int bc;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk     (clk),
    .reset_n (rst_v[0]),
    .start   (st_v[0]),
    .a       (a_v[0]),
    .shamt   (sh_v[0]),
    .op      (op_v[0]),
    .busy    (busy_v[0]),
    .done    (done_v[0]),
    .y       (y_v[0])
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk     (clk),
    .reset_n (rst_v[1]),
    .start   (st_v[1]),
    .a       (a_v[1]),
    .shamt   (sh_v[1]),
    .op      (op_v[1]),
    .busy    (busy_v[1]),
    .done    (done_v[1]),
    .y       (y_v[1])
  );

  function automatic logic [31:0] model(
    logic [31:0] x, int s, logic [1:0] o);
    logic [31:0] r;
    case (o)
      2'b00: r = x << s;
      2'b01: r = x >> s;
      2'b10: begin
        r = x;
        for (int i = 0; i < s; i++) r = {x[31], r[31:1]};
      end
      default: begin
        r = x;
        for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
      end
    endcase
    return r;
  endfunction

  task automatic start_op(int d, logic [31:0] av,
                          logic [4:0] sh, logic [1:0] o);
    a_v[d]  = av;
    sh_v[d] = sh;
    op_v[d] = o;
    st_v[d] = 1'b1;
    @(posedge clk); #1;
    st_v[d] = 1'b0;
    a_v[d]  = $urandom;
    sh_v[d] = 5'($urandom);
    op_v[d] = 2'($urandom);
    lat = 0;
    bc  = 0;
  endtask

  task automatic wait_done(int d);
    while (done_v[d] !== 1'b1 && lat < 200) begin
      if (busy_v[d] === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat >= 200)
      $display("FAIL timeout d=%0d: no done within %0d cycles", d, lat);
    else passed++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b0;
      st_v[d]  = 1'b0;
      a_v[d]   = '0;
      sh_v[d]  = '0;
      op_v[d]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) rst_v[d] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || y_v[d] !== '0)
        $display("FAIL reset d=%0d: busy=%b done=%b y=%h want 0 0 0",
                 d, busy_v[d], done_v[d], y_v[d]);
      else passed++;
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'h1, 32'h80000000, 32'h80000000,
                            32'h1, 32'h12345678, 32'hDEADBEEF};
    int          vs [6] = '{31, 4, 4, 1, 0, 31};
    logic [1:0]  vo [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
    logic [31:0] vy [6] = '{32'h80000000, 32'hF8000000, 32'h08000000,
                            32'h80000000, 32'h12345678, 32'hFFFFFFFF};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) begin
        int el;
        start_op(d, va[i], 5'(vs[i]), vo[i]);
        wait_done(d);
        el = (vs[i] + steps[d] - 1) / steps[d];
        total++;
        if (y_v[d] !== vy[i])
          $display("FAIL dir_y d=%0d i=%0d: y=%h want %h",
                   d, i, y_v[d], vy[i]);
        else passed++;
        total++;
        if (lat != el || bc != el)
          $display("FAIL dir_lat d=%0d i=%0d: lat=%0d busy=%0d want %0d",
                   d, i, lat, bc, el);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || y_v[d] !== vy[i])
          $display("FAIL dir_pulse d=%0d i=%0d: done=%b busy=%b y=%h want 0 0 %h",
                   d, i, done_v[d], busy_v[d], y_v[d], vy[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_ignore_start();
    start_op(0, 32'hFFFFFFFF, 5'd8, 2'b00);
    repeat (2) begin
      @(posedge clk); #1;
      lat++;
    end
    a_v[0]  = '0;
    op_v[0] = 2'b01;
    sh_v[0] = 5'd3;
    st_v[0] = 1'b1;
    @(posedge clk); #1;
    lat++;
    st_v[0] = 1'b0;
    wait_done(0);
    total++;
    if (y_v[0] !== 32'hFFFFFF00 || lat != 8)
      $display("FAIL ignore_start: y=%h lat=%0d want ffffff00 8",
               y_v[0], lat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    x = $urandom;
    start_op(0, x, 5'd5, 2'b11);
    total++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0)
      $display("FAIL b2b_busy: busy=%b done=%b want 1 0",
               busy_v[0], done_v[0]);
    else passed++;
    wait_done(0);
    total++;
    if (y_v[0] !== model(x, 5, 2'b11) || lat != 5)
      $display("FAIL b2b_y: y=%h lat=%0d want %h 5",
               y_v[0], lat, model(x, 5, 2'b11));
    else passed++;
    start_op(0, 32'hCAFEF00D, 5'd0, 2'b10);
    total++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || y_v[0] !== 32'hCAFEF00D)
      $display("FAIL b2b_zero: done=%b busy=%b y=%h want 1 0 cafef00d",
               done_v[0], busy_v[0], y_v[0]);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] x;
    int seen;
    x = 32'hA5A5F0F0;
    start_op(0, x, 5'd20, 2'b01);
    repeat (4) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || y_v[0] !== '0)
      $display("FAIL abort: busy=%b done=%b y=%h want 0 0 0",
               busy_v[0], done_v[0], y_v[0]);
    else passed++;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || y_v[0] !== '0)
      $display("FAIL abort_quiet: activity=%0d y=%h want 0 0",
               seen, y_v[0]);
    else passed++;
    start_op(0, x, 5'd20, 2'b01);
    wait_done(0);
    total++;
    if (y_v[0] !== 32'h00000A5A || lat != 20)
      $display("FAIL abort_restart: y=%h lat=%0d want 00000a5a 20",
               y_v[0], lat);
    else passed++;
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        logic [31:0] x;
        logic [4:0]  s;
        logic [1:0]  o;
        logic [31:0] ey;
        x  = $urandom;
        s  = 5'($urandom_range(0, 31));
        o  = 2'($urandom_range(0, 3));
        ey = model(x, int'(s), o);
        start_op(d, x, s, o);
        wait_done(d);
        total++;
        if (y_v[d] !== ey || lat != (int'(s) + steps[d] - 1) / steps[d])
          $display("FAIL rand d=%0d a=%h s=%0d op=%0d: y=%h lat=%0d want %h",
                   d, x, s, o, y_v[d], lat, ey);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle shift unit for the multicycle MIPS datapath. It performs SLL, SRL, SRA and ROTR on a 32-bit operand, shifting STEP bits per clock.
- Replaces the combinational shifter where area matters. It uses a start/busy/done handshake towards the multicycle control FSM.
- The result register holds its value until the next operation completes.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEP, 1, bits shifted per cycle. Legal values are 1, 2, 4 and 8; other values are a compile-time error.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request a new operation; sampled on the rising edge.
- a  in  WIDTH  operand; captured when start is accepted.
- shamt  in  $clog2(WIDTH)  shift amount, 0..WIDTH-1; captured when start is accepted.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR; captured when start is accepted.
- busy  out  1  high while shifting; start is ignored while busy.
- done  out  1  one-cycle pulse; y is valid in this cycle.
- y  out  WIDTH  result register.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; busy=0, done=0, y=0.
  - Internal working register and remaining count are cleared.
  - Reset during SHIFT aborts the operation: no done pulse, y=0.
- State machine: states are IDLE, SHIFT, DONE.
  - busy=1 only in SHIFT.
  - done=1 only in DONE.
- Accepting start:
  - start is accepted when the state is IDLE or DONE; this allows back-to-back operation.
  - start in SHIFT is ignored; captured operands are not disturbed.
- Accept edge k with shamt=0:
  - y<=a, state<=DONE.
  - done is high in the cycle after edge k.
- Accept edge k with shamt>0:
  - work<=a, rem<=shamt, op latched, state<=SHIFT.
- Each SHIFT edge:
  - n=min(STEP, rem); work<=step(work, n, op); rem<=rem-n.
  - If rem-n==0, y<=step result and state<=DONE.
- Latency: done is high in the cycle after edge k+ceil(shamt/STEP). Example: STEP=1, shamt=31 gives done 31 edges after the accept edge.
- DONE:
  - Lasts exactly one cycle.
  - Next state is SHIFT or DONE if start is accepted, else IDLE.
  - y holds its value in IDLE and across later operations until overwritten at the next completion.
- Arithmetic:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with bit WIDTH-1 of the operand captured at accept; the sign stays stable across steps because the working MSB is preserved.
  - ROTR is a right rotate; bits leaving bit 0 re-enter at bit WIDTH-1.
  - All results are taken modulo WIDTH bits; bits shifted out are discarded.
- Inputs a, shamt and op may change freely after the accept edge without affecting the operation in flight.
- Reset has priority over start at the same edge.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ROTR}.
  - typedef enum state_e {S_IDLE, S_SHIFT, S_DONE}.
  - Constant SHAMT_W = $clog2(WIDTH).
- One sub-module, shift_step:
  - Combinational; inputs work, n (0..STEP), op; output is the shifted word.
  - Instantiated once and reused every cycle.
- seq_shifter contains the FSM, the work/rem/op registers and the y register.

Test Plan:
- STEP=1, a=32'h00000001, shamt=31, op=SLL → busy high for 31 cycles, done pulse 31 edges after accept, y=32'h80000000.
- a=32'h80000000, shamt=4, op=SRA → y=32'hF8000000. Same stimulus with op=SRL → y=32'h08000000.
- a=32'h00000001, shamt=1, op=ROTR → y=32'h80000000. a=32'h12345678, shamt=0, any op → done in the cycle after accept, y=32'h12345678, busy never asserted.
- Start an SLL of 32'hFFFFFFFF by 8. At edge 3, re-assert start with a=0 and change a/op → new start ignored, y=32'hFFFFFF00. Then assert start during the done cycle → second operation accepted with no idle gap.
- Assert reset_n=0 mid-SHIFT (SRL by 20, edge 5) → busy=0, done never pulses, y=0 on the next cycle. A new start after reset completes normally.
- STEP=4, a=32'h00000001, shamt=31, op=SLL → done 8 edges after accept, y=32'h80000000. Also run random a/shamt/op against the << / >> / >>> / rotate model in both STEP=1 and STEP=4 builds.
